// File: rtl/rom_copy_dma_pkg.sv
// Shared definitions for the ROM-to-RAM boot copy engine.
package rom_copy_dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES      = 4;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/rom_copy_dma.sv
// Boot-time copy engine: streams words from a synchronous ROM port into a RAM
// write port at one word per cycle, honouring RAM back-pressure.
module rom_copy_dma
    import rom_copy_dma_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            src_base,
    input  logic [31:0]            dst_base,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   rom_enable,
    output logic [31:0]            rom_address,
    input  logic [31:0]            rom_data,
    output logic [31:0]            ram_address,
    output logic [31:0]            ram_data,
    output logic                   ram_write_enable,
    input  logic                   ram_stall
);

    state_t                 state, state_next;
    logic [31:0]            src, dst;
    logic [COUNT_WIDTH-1:0] count, issued, written;
    logic                   pending;
    logic                   accept, last_accept;

    always_comb begin
        accept           = pending && !ram_stall;
        last_accept      = accept && ((written + COUNT_WIDTH'(1)) == count);
        // The ROM holds its output, so a stalled write simply blocks the next read.
        rom_enable       = (state == RUN) && (issued < count) && (!pending || !ram_stall);
        rom_address      = src + 32'(issued) * WORD_BYTES;
        ram_address      = dst + 32'(written) * WORD_BYTES;
        ram_write_enable = pending;
        ram_data         = pending ? rom_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_accept) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src     <= '0;
            dst     <= '0;
            count   <= '0;
            issued  <= '0;
            written <= '0;
            pending <= 1'b0;
        end else if (state == IDLE && start) begin
            src     <= src_base & ADDR_ALIGN_MASK;
            dst     <= dst_base & ADDR_ALIGN_MASK;
            count   <= word_count;
            issued  <= '0;
            written <= '0;
            pending <= 1'b0;
        end else begin
            if (rom_enable) begin
                issued <= issued + COUNT_WIDTH'(1);
            end
            if (accept) begin
                written <= written + COUNT_WIDTH'(1);
            end
            // A same-cycle issue and accept keeps pending set for full throughput.
            if (rom_enable) begin
                pending <= 1'b1;
            end else if (accept) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_copy_dma.sv
// Directed self-checking bench for rom_copy_dma with a holding synchronous ROM model.
module tb_rom_copy_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_base, dst_base;
    logic [15:0] word_count;
    logic        busy, done, rom_enable, ram_write_enable, ram_stall;
    logic [31:0] rom_address, rom_data, ram_address, ram_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned c0;

    logic [31:0] ra_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int unsigned wc_q[$];
    int unsigned busy_n;
    int unsigned done_cyc;
    logic        done_seen;

    rom_copy_dma #(.COUNT_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .src_base         (src_base),
        .dst_base         (dst_base),
        .word_count       (word_count),
        .busy             (busy),
        .done             (done),
        .rom_enable       (rom_enable),
        .rom_address      (rom_address),
        .rom_data         (rom_data),
        .ram_address      (ram_address),
        .ram_data         (ram_data),
        .ram_write_enable (ram_write_enable),
        .ram_stall        (ram_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_val(input logic [31:0] a);
        case (a)
            32'h100: rom_val = 32'h1111_1111;
            32'h104: rom_val = 32'h2222_2222;
            32'h108: rom_val = 32'h3333_3333;
            32'h10C: rom_val = 32'h4444_4444;
            default: rom_val = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    initial rom_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_enable) rom_data <= rom_val(rom_address);
    end

    always @(negedge clk) begin
        if (rom_enable) ra_q.push_back(rom_address);
        if (ram_write_enable && !ram_stall) begin
            wa_q.push_back(ram_address);
            wd_q.push_back(ram_data);
            wc_q.push_back(cyc);
        end
        if (busy) busy_n++;
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ra_q.delete();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        busy_n    = 0;
        done_seen = 1'b0;
        done_cyc  = 0;
    endtask

    // Leaves the bench in cycle c0+1 with start deasserted.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        step();
        clear_logs();
        src_base   = s;
        dst_base   = d;
        word_count = n;
        start      = 1'b1;
        c0         = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (done_seen) break;
            step();
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        step();
        step();
    endtask

    task automatic check_writes(input string tag, input logic [31:0] s, input logic [31:0] d,
                                input int unsigned n, input int unsigned first_off);
        check({tag, "_nwrites"}, 32'(wa_q.size()), n);
        for (int i = 0; i < int'(n) && i < wa_q.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), wa_q[i], d + 32'(4 * i));
            check($sformatf("%s_wdata%0d", tag, i), wd_q[i], rom_val(s + 32'(4 * i)));
            check($sformatf("%s_wcyc%0d", tag, i), wc_q[i] - c0, first_off + 32'(i));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},        32'(busy), 32'd0);
        check({tag, "_done"},        32'(done), 32'd0);
        check({tag, "_rom_enable"},  32'(rom_enable), 32'd0);
        check({tag, "_rom_address"}, rom_address, 32'd0);
        check({tag, "_ram_address"}, ram_address, 32'd0);
        check({tag, "_ram_data"},    ram_data, 32'd0);
        check({tag, "_ram_we"},      32'(ram_write_enable), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        src_base   = '0;
        dst_base   = '0;
        word_count = '0;
        ram_stall  = 1'b0;
        clear_logs();
        step();
        step();
        check_idle_outputs("reset");
        reset = 1'b0;
        step();

        // Basic 4-word copy
        do_start(32'h100, 32'h2000, 16'd4);
        check("basic_first_rom_en", 32'(rom_enable), 32'd1);
        check("basic_first_rom_addr", rom_address, 32'h100);
        wait_done("basic");
        check_writes("basic", 32'h100, 32'h2000, 4, 2);
        check("basic_wdata0_literal", wd_q[0], 32'h1111_1111);
        check("basic_wdata3_literal", wd_q[3], 32'h4444_4444);
        check("basic_done_cyc", done_cyc - c0, 32'd6);
        check("basic_busy_cycles", busy_n, 32'd5);

        // Zero-length transfer
        do_start(32'h100, 32'h2000, 16'd0);
        wait_done("zero");
        check("zero_rom_reads", 32'(ra_q.size()), 32'd0);
        check("zero_nwrites", 32'(wa_q.size()), 32'd0);
        check("zero_done_cyc", done_cyc - c0, 32'd1);
        check("zero_busy_cycles", busy_n, 32'd0);

        // RAM stall for three cycles on the first write
        do_start(32'h200, 32'h3000, 16'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            ram_stall = 1'b1;
            #1;
            check($sformatf("stall_addr%0d", k), ram_address, 32'h3000);
            check($sformatf("stall_data%0d", k), ram_data, rom_val(32'h200));
            check($sformatf("stall_rom_en%0d", k), 32'(rom_enable), 32'd0);
        end
        step();
        ram_stall = 1'b0;
        wait_done("stall");
        check_writes("stall", 32'h200, 32'h3000, 3, 5);
        check("stall_done_cyc", done_cyc - c0, 32'd8);

        // Second start pulse mid-transfer must be ignored
        do_start(32'h100, 32'h4000, 16'd8);
        step();
        step();
        src_base   = 32'h800;
        dst_base   = 32'h9000;
        word_count = 16'd2;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_done("rebusy");
        check_writes("rebusy", 32'h100, 32'h4000, 8, 2);
        check("rebusy_done_cyc", done_cyc - c0, 32'd10);

        // Reset after two of six writes
        do_start(32'h100, 32'h5000, 16'd6);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("midrst");
        step();
        step();
        check("midrst_nwrites", 32'(wa_q.size()), 32'd2);
        check("midrst_no_done", 32'(done_seen), 32'd0);
        do_start(32'h100, 32'h6000, 16'd2);
        wait_done("postrst");
        check_writes("postrst", 32'h100, 32'h6000, 2, 2);

        // Unaligned source wrapping past the top of the address space
        do_start(32'hFFFF_FFFA, 32'h7000, 16'd3);
        wait_done("wrap");
        check("wrap_nreads", 32'(ra_q.size()), 32'd3);
        check("wrap_raddr0", ra_q[0], 32'hFFFF_FFF8);
        check("wrap_raddr1", ra_q[1], 32'hFFFF_FFFC);
        check("wrap_raddr2", ra_q[2], 32'h0000_0000);
        check_writes("wrap", 32'hFFFF_FFF8, 32'h7000, 3, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
